// File: rtl/adder_pkg.sv
// Shared constants, operation encoding and saturation-limit helper for the pipelined adder.
package adder_pkg;

    localparam int ADDER_W_DEFAULT      = 32;
    localparam int ADDER_STAGES_DEFAULT = 4;
    localparam int ADDER_W_MAX          = 256;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } adder_op_e;

    // Most-negative (neg=1) or most-positive (neg=0) two's-complement value of the given width.
    function automatic logic [ADDER_W_MAX-1:0] signed_limit(input int width, input logic neg);
        logic [ADDER_W_MAX-1:0] msb;
        msb = '0;
        msb[width-1] = 1'b1;
        return neg ? msb : msb - {{(ADDER_W_MAX-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe; master = producer/consumer side, slave = adder.
interface adder_pipe_if
    import adder_pkg::*;
#(
    parameter int n = ADDER_W_DEFAULT
);

    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/adder_slice.sv
// Combinational w-bit ripple slice: {co, s} = x + y + ci.
module adder_slice #(
    parameter int w = 8
) (
    input  logic [w-1:0] x,
    input  logic [w-1:0] y,
    input  logic         ci,
    output logic [w-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{w{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe.sv
// Pipelined a +/- b + cin over `stages` slices with a global-stall valid/ready handshake.
// Optional macro ADDER_PIPE_SAT_EN clamps the result to the signed limit on overflow.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int n      = ADDER_W_DEFAULT,
    parameter int stages = ADDER_STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    adder_pipe_if.slave  io
);

    localparam int w = n / stages;

    if (stages < 1 || stages > n || (n % stages) != 0) begin : g_bad_cfg
        $error("adder_pipe: n must be a multiple of stages, 1 <= stages <= n");
    end

    adder_op_e    op;
    logic [n-1:0] beff;
    logic         ceff;
    logic         adv;

    assign op   = adder_op_e'(io.sub);
    assign beff = (op == SUB) ? ~io.b : io.b;
    assign ceff = io.cin ^ (op == SUB);

    // Whole pipe advances together: empty stages stall too, which keeps control to one signal.
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    for (genvar k = 0; k < stages; k++) begin : stage
        localparam int HI = n - (k + 1) * w;

        logic [w-1:0]         x, y, s;
        logic                 ci, co, vin;
        logic [(k+1)*w-1:0]   s_nxt, s_load, s_q;
        logic                 c_q, v_q;

        if (k == 0) begin : g_src
            assign x     = io.a[w-1:0];
            assign y     = beff[w-1:0];
            assign ci    = ceff;
            assign vin   = io.in_valid;
            assign s_nxt = s;
        end else begin : g_src
            assign x     = stage[k-1].g_skew.a_hi_q[w-1:0];
            assign y     = stage[k-1].g_skew.b_hi_q[w-1:0];
            assign ci    = stage[k-1].c_q;
            assign vin   = stage[k-1].v_q;
            assign s_nxt = {s, stage[k-1].s_q};
        end

        adder_slice #(.w(w)) u_slice (
            .x  (x),
            .y  (y),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        // Operand slices not yet summed ride along with their partial result.
        if (k < stages - 1) begin : g_skew
            logic [HI-1:0] a_hi_nxt, b_hi_nxt, a_hi_q, b_hi_q;

            if (k == 0) begin : g_hi_src
                assign a_hi_nxt = io.a[n-1:w];
                assign b_hi_nxt = beff[n-1:w];
            end else begin : g_hi_src
                assign a_hi_nxt = stage[k-1].g_skew.a_hi_q[HI+w-1:w];
                assign b_hi_nxt = stage[k-1].g_skew.b_hi_q[HI+w-1:w];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (adv) begin
                    a_hi_q <= a_hi_nxt;
                    b_hi_q <= b_hi_nxt;
                end
            end
        end

        if (k == stages - 1) begin : g_last
            logic ovf, ovf_q;

            assign ovf = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
`ifdef ADDER_PIPE_SAT_EN
            assign s_load = ovf ? n'(signed_limit(n, x[w-1])) : s_nxt;
`else
            assign s_load = s_nxt;
`endif

            always_ff @(posedge clk) begin
                if (reset)    ovf_q <= 1'b0;
                else if (adv) ovf_q <= ovf;
            end
        end else begin : g_mid
            assign s_load = s_nxt;
        end

        // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vin;
                c_q <= co;
                s_q <= s_load;
            end
        end
    end

    assign io.out_valid = stage[stages-1].v_q;
    assign io.sum       = stage[stages-1].s_q;
    assign io.cout      = stage[stages-1].c_q;
    assign io.overflow  = stage[stages-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed scoreboard bench for adder_pipe (n=32, stages=4): driver pushes expectations, monitor pops.
module tb_adder_pipe;

    localparam int N      = 32;
    localparam int STAGES = 4;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
        bit           lat;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [N-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    bit           exp_lat;

    adder_pipe_if #(.n(N)) bus ();

    adder_pipe #(.n(N), .stages(STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one operand set and hold it until accepted (bounded).
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input logic sub, input logic [N-1:0] esum, input logic ecout,
                        input logic eovf, input bit lat);
        bit accepted;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;  bus.b = b;  bus.cin = cin;  bus.sub = sub;
        exp_sum = esum;  exp_cout = ecout;  exp_ovf = eovf;  exp_lat = lat;
        accepted = 1'b0;
        for (int g = 0; g < 50; g++) begin
            #4;
            if (bus.in_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (cycles - 1) @(negedge clk);
    endtask

    // Scoreboard push: record the expected result for every accepted operand set.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset && bus.in_valid && bus.in_ready)
                sb.push_back('{sum: exp_sum, cout: exp_cout, ovf: exp_ovf, cyc: cyc, lat: exp_lat});
        end
    end

    // Monitor: compare each delivered result and watch stall behaviour.
    initial begin
        logic         stall_prev;
        logic [N-1:0] held_sum;
        logic [1:0]   held_flags;
        exp_t         e;
        stall_prev = 1'b0;
        held_sum   = '0;
        held_flags = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                stall_prev = 1'b0;
                continue;
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("in_ready_stall", 32'(bus.in_ready), 32'd0);
                if (stall_prev) begin
                    check("hold_sum", bus.sum, held_sum);
                    check("hold_flags", 32'({bus.cout, bus.overflow}), 32'(held_flags));
                end
                stall_prev = 1'b1;
                held_sum   = bus.sum;
                held_flags = {bus.cout, bus.overflow};
            end else begin
                stall_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: sum=%h with nothing outstanding", bus.sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", bus.sum, e.sum);
                    check("cout", 32'(bus.cout), 32'(e.cout));
                    check("overflow", 32'(bus.overflow), 32'(e.ovf));
                    if (e.lat) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;  bus.b = '0;  bus.cin = 1'b0;  bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        exp_sum = '0;  exp_cout = 1'b0;  exp_ovf = 1'b0;  exp_lat = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #4;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", bus.sum, 32'h0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single op through an empty pipe: latency check.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Back-to-back directed vectors, never stalled.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        idle(8);

        // Eight back-to-back ops with a 3-cycle output stall starting at cycle 6.
        fork
            begin
                send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
                send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
                send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
                send(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0);
                send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                     SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1, 1'b0);
                send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
                send(32'h0000_00FF, 32'h0000_0F00, 1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
                send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                     SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
            end
            begin
                repeat (6) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        idle(12);
        check("burst_drained", 32'(sb.size()), 32'd0);

        // Reset with three ops in flight: none may ever emerge.
        send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0033, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0044, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0099, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0066, 32'h0000_0077, 1'b0, 1'b0, 32'h0000_00DD, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #4;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        idle(10);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the combinational adder. Computes a ± b + carry-in over `stages` register stages.
- Each stage adds one n/stages-bit slice and passes the carry to the next stage.
- Valid/ready handshake on both sides, so the block can sit between register-stage producers and consumers in the datapath without closing an n-bit carry chain in one cycle.
- Reports carry-out and signed overflow.

Parameters:
- n, 32, operand/result width in bits; must be a multiple of stages.
- stages, 4, number of pipeline stages (1..n); slice width w = n/stages.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  n  operand A.
- b  input  n  operand B.
- cin  input  1  carry-in (borrow-in complement in subtract mode).
- sub  input  1  0 = a+b+cin, 1 = a+~b+~cin (a−b−cin).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  n  result.
- cout  output  1  carry-out of the MSB slice; in subtract mode 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (sync, active-high) clears all stage valid bits and data registers. Outputs: out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 the cycle after reset deasserts.
- Operand conditioning at input:
  - beff = b ^ {n{sub}}
  - ceff = cin ^ sub
- Stage k (0..stages−1) adds slice k of a and beff plus the carry from stage k−1 (ceff for k=0). It registers the w-bit partial sum and the carry.
- Upper operand slices travel in skew registers alongside the data. Lower result slices travel in deskew registers, so the full sum emerges aligned.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - All stage registers, including the valid bits, load only when adv=1. When adv=0 every stage holds.
- Transfers:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
- Latency is exactly `stages` cycles from input transfer to out_valid when never stalled. Throughput is 1 result/cycle.
- No bubble collapsing: empty stages also stall when the output is blocked. This is deliberate, to keep control minimal.
- out_valid is the last stage's valid bit. sum, cout and overflow hold stable while out_valid && !out_ready.
- Output flags:
  - overflow = (a[n−1] == beff[n−1]) && (sum[n−1] != a[n−1]), computed in the final stage from the skewed sign bits.
  - cout = carry out of slice stages−1.
- Arithmetic is modulo 2^n; sum wraps without saturation (see Optional Feature).
- in_valid=0 while adv=1 inserts a bubble (valid bit 0). Data registers still load but are don't-care.
- Simultaneous output transfer and input transfer in the same cycle are legal; the pipeline shifts by one.
- Reset mid-operation discards all in-flight results. No partial output is produced.
- stages=1: a single registered adder with latency 1.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined: when overflow=1 in the final stage, sum is clamped.
  - 0x7FF..F if a[n−1]=0.
  - 0x800..0 if a[n−1]=1.
  - overflow is still reported. cout is unaffected.
- Undefined: wrap-around result only. No extra logic.

Decomposition:
- Package adder_pkg:
  - ADDER_W_DEFAULT=32, ADDER_STAGES_DEFAULT=4.
  - typedef adder_op_e {ADD=1'b0, SUB=1'b1}.
  - Function to compute the signed min/max constants for width n.
- One sub-module adder_slice:
  - Parameter w; ports x[w], y[w], ci, s[w], co.
  - Purely combinational.
  - Instantiated per stage by generate.

Test Plan (n=32, stages=4):
- Reset, then a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0 with out_ready=1 -> out_valid rises exactly 4 cycles after transfer; sum=0x0000_0100, cout=0, overflow=0.
- a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 (cross-slice carry) -> sum=0x0000_0000, cout=1, overflow=0.
- a=0x7FFF_FFFF, b=0x0000_0001 -> overflow=1; sum=0x8000_0000 without macro, 0x7FFF_FFFF with ADDER_PIPE_SAT_EN.
- sub=1, a=5, b=7, cin=0 -> sum=0xFFFF_FFFE, cout=0 (borrow), overflow=0; a=7, b=5 -> sum=2, cout=1.
- Back-to-back 8 inputs with out_ready held 0 from cycle 6 for 3 cycles -> in_ready=0 while out_valid && !out_ready; outputs stable; all 8 results delivered in order with no loss or duplication.
- Reset asserted with 3 operations in flight -> out_valid=0 next cycle; none of the in-flight results ever appear.
